// File: rtl/instr_fetch.sv
// instr_fetch: RV32I fetch stage. Owns the PC, issues imem word reads, buffers
// in-order responses and hands {inst, inst_pc} to decode; redirects squash.
// Ports: clk, rst_n; imem_req_{valid,ready,addr}; imem_resp_{valid,data};
//        redirect_{valid,pc}; inst_{valid,ready}, inst, inst_pc.
module instr_fetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] FULL = DEPTH[CW:0];

  logic [31:0]      pc;
  logic [31:0]      buf_pc   [DEPTH];
  logic [31:0]      buf_data [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW-1:0]    fill;
  logic [CW-1:0]    count;
  logic [CW-1:0]    pend;
  logic [CW-1:0]    drop_cnt;
  logic [CW-1:0]    inflight;
  logic [CW:0]      used;
  logic             accept;
  logic             pop;
  logic             resp_drop;
  logic             resp_fill;

  // Credits cover both live entries and responses still owed to
  // squashed streams, so a stale response never lands on a live slot.
  assign used           = {1'b0, count} + {1'b0, drop_cnt};
  assign imem_req_valid = !redirect_valid && (used < FULL);
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign inst_valid = filled[head] && !redirect_valid;
  assign inst       = buf_data[head];
  assign inst_pc    = buf_pc[head];
  assign pop        = inst_valid && inst_ready;

  // A response with nothing outstanding matches neither case: ignored.
  assign resp_drop = imem_resp_valid && (drop_cnt != '0);
  assign resp_fill = imem_resp_valid && (drop_cnt == '0)
                  && (pend != '0);
  assign inflight  = drop_cnt + pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      fill     <= '0;
      count    <= '0;
      pend     <= '0;
      drop_cnt <= '0;
      filled   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        buf_pc[i]   <= '0;
        buf_data[i] <= '0;
      end
    end else if (redirect_valid) begin
      pc     <= {redirect_pc[31:2], 2'b00};
      head   <= '0;
      tail   <= '0;
      fill   <= '0;
      count  <= '0;
      pend   <= '0;
      filled <= '0;
      // A response in this cycle retires one owed slot.
      if (imem_resp_valid && (inflight != '0))
        drop_cnt <= inflight - CW'(1);
      else
        drop_cnt <= inflight;
    end else begin
      if (accept) begin
        buf_pc[tail] <= pc;
        tail         <= tail + PW'(1);
        pc           <= pc + 32'd4;
      end
      if (resp_fill) begin
        buf_data[fill] <= imem_resp_data;
        filled[fill]   <= 1'b1;
        fill           <= fill + PW'(1);
      end
      if (resp_drop)
        drop_cnt <= drop_cnt - CW'(1);
      if (pop) begin
        filled[head] <= 1'b0;
        head         <= head + PW'(1);
      end
      count <= count + CW'(accept) - CW'(pop);
      pend  <= pend + CW'(accept) - CW'(resp_fill);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized bench for instr_fetch with an in-order memory
// model and a stream-level reference of what fetch should request/deliver.
module tb_instr_fetch;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  instr_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  typedef struct packed {
    logic [31:0] addr;
    int unsigned ep;
    int unsigned due;
  } req_t;

  req_t        mem_q[$];
  logic [31:0] rdy_q[$];
  logic [31:0] mpc;
  int unsigned ep;
  int unsigned cyc;
  bit          prev_redir;
  int          n_cmp;
  int          n_err;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[7:0], 24'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int unsigned p_rdy, input int unsigned p_ack,
                      input int unsigned p_redir, input int unsigned p_resp,
                      input int unsigned lat_max, input int unsigned p_co);
    int unsigned live;
    int unsigned stale;
    bit          e_rv;
    bit          e_iv;
    req_t        r;
    @(negedge clk);
    imem_req_ready  = ($urandom_range(99) < p_rdy);
    inst_ready      = ($urandom_range(99) < p_ack);
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (mem_q.size() > 0) begin
      if (mem_q[0].due <= cyc && $urandom_range(99) < p_resp) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = word_of(mem_q[0].addr);
      end
    end else if ($urandom_range(99) < 5) begin
      imem_resp_valid = 1'b1;
    end
    redirect_valid = !prev_redir && ($urandom_range(99) < p_redir);
    if ($urandom_range(3) == 0)
      redirect_pc = 32'hFFFF_FFF4 | 32'($urandom_range(3));
    else
      redirect_pc = $urandom & 32'h0000_FFFF;
    if (!prev_redir && imem_resp_valid && mem_q.size() > 0
        && $urandom_range(99) < p_co) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0203;
    end
    #1;
    live  = rdy_q.size();
    stale = 0;
    foreach (mem_q[i]) begin
      if (mem_q[i].ep == ep) live++;
      else stale++;
    end
    e_rv = !redirect_valid && (live + stale < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(e_rv));
    if (e_rv) chk("req_addr", imem_req_addr, mpc);
    e_iv = (rdy_q.size() > 0) && !redirect_valid;
    chk("inst_valid", 32'(inst_valid), 32'(e_iv));
    if (e_iv) begin
      chk("inst_pc", inst_pc, rdy_q[0]);
      chk("inst", inst, word_of(rdy_q[0]));
    end
    if (imem_resp_valid && mem_q.size() > 0) begin
      r = mem_q.pop_front();
      if (!redirect_valid && r.ep == ep) rdy_q.push_back(r.addr);
    end
    if (redirect_valid) begin
      ep++;
      rdy_q.delete();
      mpc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (e_rv && imem_req_ready) begin
        mem_q.push_back('{mpc, ep, cyc + $urandom_range(lat_max, 1)});
        mpc = mpc + 32'd4;
      end
      if (e_iv && inst_ready) void'(rdy_q.pop_front());
    end
    prev_redir = redirect_valid;
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    int k;
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    ep = 0;
    prev_redir = 1'b0;
    mpc = RESET_PC;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    inst_ready      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (40) step(100, 100, 0, 100, 1, 0);
    repeat (12) step(100, 0, 0, 100, 1, 0);
    repeat (20) step(100, 100, 0, 100, 1, 0);
    repeat (6) step(0, 100, 0, 100, 1, 0);
    repeat (20) step(100, 100, 0, 100, 3, 0);
    repeat (1500) step(70, 70, 4, 70, 3, 0);
    repeat (300) step(85, 80, 0, 85, 3, 25);

    k = 0;
    while (rdy_q.size() < 2 && k < 50) begin
      step(100, 0, 0, 100, 1, 0);
      k++;
    end
    chk("fill_timeout", 32'(rdy_q.size() >= 2), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_inst_valid", 32'(inst_valid), 32'd0);
    chk("async_req_addr", imem_req_addr, RESET_PC);
    chk("async_req_valid", 32'(imem_req_valid), 32'd1);
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    mem_q.delete();
    rdy_q.delete();
    mpc = RESET_PC;
    ep++;
    prev_redir = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) step(80, 80, 3, 80, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
